alu_const_select_gen: RTL and testbench

- Sequential producer of the one-hot constant-select lines consumed by the ALU direct-constant input mux.
- Accepts constant requests from the control sequencer over a valid/ready handshake: RST vector, bit mask, high page, DAA correction, NMI vector, BCD complement, high-one.
- Computes DAA correction from the accumulator and flags.
- Presents the result as a registered select vector with its own valid/ready handshake toward the operand-latch stage.

---
 rtl/alu_const_select_gen_pkg.sv | 40 ++++
 rtl/alu_const_select_decode.sv | 31 +++
 rtl/alu_const_select_gen.sv | 77 +++++++
 tb/tb_alu_const_select_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_const_select_gen_pkg.sv
// alu_const_select_gen_pkg: shared encodings for the ALU constant-select generator
// Holds request kinds, select-bit positions, the select width and a one-hot helper.
package alu_const_select_gen_pkg;
  localparam int SEL_W = 18;
  typedef enum logic [2:0] {
    KIND_RST, KIND_BITMASK, KIND_HIGHPAGE, KIND_DAA,
    KIND_NMI, KIND_BCDCOMP, KIND_HIGH1, KIND_RSVD
  } kind_e;
  localparam int SEL_0x1_HIGH = 0;
  localparam int SEL_0xFF00   = 1;
  localparam int SEL_0x01     = 2;
  localparam int SEL_0x08     = 3;
  localparam int SEL_0x10     = 4;
  localparam int SEL_0x18     = 5;
  localparam int SEL_0x20     = 6;
  localparam int SEL_0x28     = 7;
  localparam int SEL_0x30     = 8;
  localparam int SEL_0x38     = 9;
  localparam int SEL_0x66     = 10;
  localparam int SEL_0x99     = 11;
  localparam int SEL_0x06     = 12;
  localparam int SEL_0x60     = 13;
  localparam int SEL_0x02     = 14;
  localparam int SEL_0x04     = 15;
  localparam int SEL_0x40     = 16;
  localparam int SEL_0x80     = 17;
  localparam int BIT_POS [8] = '{SEL_0x01, SEL_0x02, SEL_0x04, SEL_0x08,
                                 SEL_0x10, SEL_0x20, SEL_0x40, SEL_0x80};
  typedef struct packed {
    kind_e      kind;
    logic [2:0] idx;
    logic [7:0] acc;
    logic       h;
    logic       c;
    logic       n;
  } req_t;
  function automatic logic [SEL_W-1:0] onehot(input int b);
    return {{(SEL_W-1){1'b0}}, 1'b1} << b;
  endfunction
endpackage

// File: rtl/alu_const_select_decode.sv
// alu_const_select_decode: combinational request -> one-hot constant select
// req_i: captured request; sel_o: one-hot-or-zero select; daa_c_o: DAA carry; err_o: reserved kind.
module alu_const_select_decode
  import alu_const_select_gen_pkg::*;
(
  input  req_t             req_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             daa_c_o,
  output logic             err_o
);
  logic lo_adj, hi_adj;
  assign lo_adj = req_i.h | (!req_i.n & (req_i.acc[3:0] > 4'd9));
  assign hi_adj = req_i.c | (!req_i.n & (req_i.acc > 8'h99));
  always_comb begin
    sel_o = '0;
    case (req_i.kind)
      KIND_RST:      sel_o = (req_i.idx == 3'd0) ? '0 : onehot(SEL_0x08 + int'(req_i.idx) - 1);
      KIND_BITMASK:  sel_o = onehot(BIT_POS[req_i.idx]);
      KIND_HIGHPAGE: sel_o = onehot(SEL_0xFF00);
      KIND_DAA:      sel_o = (lo_adj & hi_adj) ? onehot(SEL_0x66) :
                             lo_adj ? onehot(SEL_0x06) :
                             hi_adj ? onehot(SEL_0x60) : '0;
      KIND_NMI:      sel_o = onehot(SEL_0x66);
      KIND_BCDCOMP:  sel_o = onehot(SEL_0x99);
      KIND_HIGH1:    sel_o = onehot(SEL_0x1_HIGH);
      default:       sel_o = '0;
    endcase
  end
  assign daa_c_o = (req_i.kind == KIND_DAA) & hi_adj;
  assign err_o   = req_i.kind == KIND_RSVD;
endmodule

// File: rtl/alu_const_select_gen.sv
// alu_const_select_gen: pipelined producer of ALU constant-select lines
// Request side: req_valid/req_ready with req_kind, req_idx, acc, flag_h/c/n.
// Result side: sel, daa_c_out with sel_valid/sel_ready; err_kind pulses when a reserved result is issued.
module alu_const_select_gen
  import alu_const_select_gen_pkg::*;
#(
  parameter int PIPE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_kind,
  input  logic [2:0]       req_idx,
  input  logic [7:0]       acc,
  input  logic             flag_h,
  input  logic             flag_c,
  input  logic             flag_n,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic             daa_c_out,
  output logic             err_kind
);
  req_t             req_in, dec_in;
  logic             dec_v, dec_c, dec_err, out_adv;
  logic [SEL_W-1:0] dec_sel, sel_q;
  logic             sel_valid_q, daa_c_q, err_q;
  assign req_in = '{kind: kind_e'(req_kind), idx: req_idx, acc: acc, h: flag_h, c: flag_c, n: flag_n};
  assign out_adv = !sel_valid_q | sel_ready;
  generate
    if (PIPE_DEPTH == 1) begin : g_p1
      assign dec_in    = req_in;
      assign dec_v     = req_valid;
      assign req_ready = out_adv;
    end else begin : g_p2
      req_t s1_q;
      logic s1_valid_q;
      // stage 1 may refill in the same cycle it drains into stage 2
      assign req_ready = !s1_valid_q | out_adv;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s1_valid_q <= 1'b0;
          s1_q       <= '0;
        end else if (req_ready) begin
          s1_valid_q <= req_valid;
          s1_q       <= req_in;
        end
      assign dec_in = s1_q;
      assign dec_v  = s1_valid_q;
    end
  endgenerate
  alu_const_select_decode u_decode (
    .req_i   (dec_in),
    .sel_o   (dec_sel),
    .daa_c_o (dec_c),
    .err_o   (dec_err)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      daa_c_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= out_adv & dec_v & dec_err;
      if (out_adv) begin
        sel_valid_q <= dec_v;
        sel_q       <= dec_v ? dec_sel : '0;
        daa_c_q     <= dec_v & dec_c;
      end
    end
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign daa_c_out = daa_c_q;
  assign err_kind  = err_q;
endmodule

// File: tb/tb_alu_const_select_gen.sv
// tb_alu_const_select_gen: scoreboard bench with value-level reference model
module tb_alu_const_select_gen;
  import alu_const_select_gen_pkg::*;
  logic        clk = 0, rst_n = 0, req_valid = 0, req_ready;
  logic        flag_h = 0, flag_c = 0, flag_n = 0;
  logic        sel_valid, sel_ready = 1, daa_c_out, err_kind;
  logic [2:0]  req_kind = 0, req_idx = 0;
  logic [7:0]  acc = 0;
  logic [17:0] sel;
  int          total = 0, bad = 0, err_exp = 0, err_seen = 0;
  bit          rand_rdy = 0;
  typedef struct {logic [17:0] sel; logic c;} exp_t;
  exp_t exp_q[$];
  exp_t e_pop;
  always #5 clk = ~clk;
  alu_const_select_gen dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_idx(req_idx), .acc(acc), .flag_h(flag_h),
    .flag_c(flag_c), .flag_n(flag_n), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .daa_c_out(daa_c_out), .err_kind(err_kind)
  );
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // constant value first, then located in the mux input table
  function automatic exp_t model(input logic [2:0] k, input logic [2:0] i, input logic [7:0] a,
                                 input logic h, input logic c, input logic n);
    int   vals[18];
    int   v;
    bit   lo, hi;
    exp_t e;
    vals = '{'h10000, 'hFF00, 'h01, 'h08, 'h10, 'h18, 'h20, 'h28, 'h30, 'h38,
             'h66, 'h99, 'h06, 'h60, 'h02, 'h04, 'h40, 'h80};
    lo = h || (!n && a[3:0] > 9);
    hi = c || (!n && int'(a) > 'h99);
    case (k)
      0: v = int'(i) * 8;
      1: v = 1 << i;
      2: v = 'hFF00;
      3: v = (lo ? 'h06 : 0) + (hi ? 'h60 : 0);
      4: v = 'h66;
      5: v = 'h99;
      6: v = 'h10000;
      default: v = 0;
    endcase
    e.sel = '0;
    e.c = (k == 3) && hi;
    for (int b = 0; b < 18; b++) if (v != 0 && vals[b] == v) e.sel[b] = 1'b1;
    return e;
  endfunction
  always @(negedge clk)
    if (rst_n && req_valid && req_ready) begin
      exp_q.push_back(model(req_kind, req_idx, acc, flag_h, flag_c, flag_n));
      if (req_kind == 3'd7) err_exp++;
    end
  logic [17:0] h_sel;
  logic        h_c;
  bit          hold = 0;
  always @(negedge clk)
    if (!rst_n) hold = 0;
    else begin
      chk($countones(sel) <= 1, "onehot", sel, 0);
      if (hold) chk(sel_valid && sel == h_sel && daa_c_out == h_c, "hold_stable", {daa_c_out, sel}, {h_c, h_sel});
      if (err_kind) err_seen++;
      if (sel_valid && sel_ready) begin
        chk(exp_q.size() > 0, "unexpected_result", sel, 0);
        if (exp_q.size() > 0) begin
          e_pop = exp_q.pop_front();
          chk(sel == e_pop.sel && daa_c_out == e_pop.c, "result", {daa_c_out, sel}, {e_pop.c, e_pop.sel});
        end
      end
      hold = sel_valid && !sel_ready;
      h_sel = sel;
      h_c = daa_c_out;
    end
  always @(posedge clk)
    if (rand_rdy) begin
      #1;
      sel_ready = 1'($urandom_range(0, 1));
    end
  task automatic send(input logic [2:0] k, input logic [2:0] i, input logic [7:0] a,
                      input logic h, input logic c, input logic n);
    int w = 0;
    req_valid = 1; req_kind = k; req_idx = i; acc = a; flag_h = h; flag_c = c; flag_n = n;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    chk(req_ready, "send_timeout", w, 200);
    @(posedge clk);
    #1;
    req_valid = 0;
    acc = 8'($urandom);
    {flag_h, flag_c, flag_n} = 3'($urandom);
  endtask
  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk(sel == 0, "rst_sel", sel, 0);
    chk(!sel_valid, "rst_sel_valid", sel_valid, 0);
    chk(req_ready, "rst_req_ready", req_ready, 1);
    chk(!daa_c_out, "rst_daa_c", daa_c_out, 0);
    chk(!err_kind, "rst_err", err_kind, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(3'd0, 3'(i), 8'($urandom), 0, 0, 0);
    drain();
    sel_ready = 0;
    fork
      for (int i = 0; i < 8; i++) send(3'd1, 3'(i), 8'($urandom), 0, 0, 0);
      begin
        int w = 0;
        logic [17:0] s;
        @(negedge clk);
        while (!sel_valid && w < 50) begin
          w++;
          @(negedge clk);
        end
        chk(sel_valid, "stall_first_result", sel_valid, 1);
        s = sel;
        repeat (5) begin
          @(negedge clk);
          chk(sel_valid && sel == s, "stall_sel", sel, s);
        end
        chk(!req_ready, "stall_full", req_ready, 0);
        @(posedge clk);
        #1 sel_ready = 1;
      end
    join
    drain();
    send(3'd3, 0, 8'h9A, 0, 0, 0);
    send(3'd3, 0, 8'h15, 1, 0, 0);
    send(3'd3, 0, 8'h45, 0, 1, 1);
    send(3'd3, 0, 8'h12, 0, 0, 0);
    send(3'd3, 0, 8'h9A, 0, 0, 0);
    acc = 8'h00;
    {flag_h, flag_c, flag_n} = 3'b001;
    send(3'd3, 0, 8'h03, 0, 0, 0);
    for (int k = 2; k < 8; k++) if (k != 3) send(3'(k), 3'($urandom), 8'($urandom), 0, 0, 0);
    drain();
    sel_ready = 0;
    send(3'd6, 0, 8'h00, 0, 0, 0);
    send(3'd2, 0, 8'h00, 0, 0, 0);
    rst_n = 0;
    #1;
    chk(!sel_valid, "midrst_sel_valid", sel_valid, 0);
    chk(sel == 0, "midrst_sel", sel, 0);
    chk(!daa_c_out, "midrst_daa_c", daa_c_out, 0);
    chk(req_ready, "midrst_req_ready", req_ready, 1);
    @(negedge clk);
    #2 rst_n = 1;
    exp_q.delete();
    sel_ready = 1;
    @(posedge clk);
    #1;
    chk(req_ready && !sel_valid, "post_rst_idle", {req_ready, sel_valid}, 2'b10);
    rand_rdy = 1;
    for (int r = 0; r < 1000; r++) begin
      n = $urandom_range(0, 2);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
      send(3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_rdy = 0;
    @(posedge clk);
    #3 sel_ready = 1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk(err_seen == err_exp, "err_count", err_seen, err_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
